// File: rtl/sdram_pkg.sv
// Shared types for the SDRAM burst engine.
// Holds the FSM state encoding and the default burst length.
package sdram_pkg;

  localparam int BURST_LEN_DEF = 256;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WR       = 3'd1,
    S_RD_ISSUE = 3'd2,
    S_RD_DRAIN = 3'd3,
    S_DONE     = 3'd4
  } state_t;

endpackage

// File: rtl/sdram_burst_engine.sv
// Burst engine: turns level write/read burst requests into
// BURST_LEN word commands on a valid/ready memory port.
// Ports: clk, reset (sync, active-high);
//   wr_burst_req/addr/data -> wr_burst_data_req, wr_burst_finish;
//   rd_burst_req/addr -> rd_burst_data(_valid), rd_burst_finish;
//   mem_cmd_valid/ready/we/addr, mem_wdata, mem_rdata(_valid).
import sdram_pkg::*;

module sdram_burst_engine #(
  parameter int ADDR_W    = 24,
  parameter int DATA_W    = 16,
  parameter int BURST_LEN = BURST_LEN_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_burst_req,
  input  logic [ADDR_W-1:0] wr_burst_addr,
  input  logic [DATA_W-1:0] wr_burst_data,
  output logic              wr_burst_data_req,
  output logic              wr_burst_finish,
  input  logic              rd_burst_req,
  input  logic [ADDR_W-1:0] rd_burst_addr,
  output logic [DATA_W-1:0] rd_burst_data,
  output logic              rd_burst_data_valid,
  output logic              rd_burst_finish,
  output logic              mem_cmd_valid,
  input  logic              mem_cmd_ready,
  output logic              mem_cmd_we,
  output logic [ADDR_W-1:0] mem_cmd_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rdata_valid
);

  localparam int CNT_W = $clog2(BURST_LEN + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(BURST_LEN);

  state_t            state_q;
  state_t            state_d;
  logic [CNT_W-1:0]  iss_q;
  logic [CNT_W-1:0]  ret_q;
  logic [ADDR_W-1:0] addr_q;
  logic              is_rd_q;
  logic              last_rd_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_vld_q;

  logic cmd_fire;
  logic last_cmd;
  logic ret_done;
  logic start;
  logic pick_rd;
  logic rd_acc;

  assign cmd_fire = mem_cmd_valid && mem_cmd_ready;
  assign last_cmd = cmd_fire && (iss_q == LAST);
  assign ret_done = (ret_q == FULL);
  assign start    = rd_burst_req || wr_burst_req;
  // On a tie, serve the type not served last time.
  assign pick_rd  = rd_burst_req &&
                    (!wr_burst_req || !last_rd_q);
  // Returns beyond one burst worth are dropped.
  assign rd_acc   = mem_rdata_valid && is_rd_q &&
                    (state_q != S_IDLE) && !ret_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = pick_rd ? S_RD_ISSUE : S_WR;
        end
      end
      S_WR: begin
        if (last_cmd) begin
          state_d = S_DONE;
        end
      end
      S_RD_ISSUE: begin
        if (last_cmd) begin
          state_d = ret_done ? S_DONE : S_RD_DRAIN;
        end
      end
      S_RD_DRAIN: begin
        // ret_done means the last word is on rd_burst_data now.
        if (ret_done) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    mem_cmd_valid     = 1'b0;
    mem_cmd_we        = 1'b0;
    mem_wdata         = '0;
    wr_burst_finish   = 1'b0;
    rd_burst_finish   = 1'b0;
    unique case (state_q)
      S_WR: begin
        mem_cmd_valid = 1'b1;
        mem_cmd_we    = 1'b1;
        mem_wdata     = wr_burst_data;
      end
      S_RD_ISSUE: begin
        mem_cmd_valid = 1'b1;
      end
      S_DONE: begin
        wr_burst_finish = !is_rd_q;
        rd_burst_finish = is_rd_q;
      end
      default: begin
      end
    endcase
    wr_burst_data_req = cmd_fire && mem_cmd_we;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      iss_q     <= '0;
      ret_q     <= '0;
      addr_q    <= '0;
      is_rd_q   <= 1'b0;
      last_rd_q <= 1'b0;
      rd_data_q <= '0;
      rd_vld_q  <= 1'b0;
    end else begin
      if (state_q == S_IDLE && start) begin
        addr_q    <= pick_rd ? rd_burst_addr : wr_burst_addr;
        iss_q     <= '0;
        ret_q     <= '0;
        is_rd_q   <= pick_rd;
        last_rd_q <= pick_rd;
      end else if (cmd_fire) begin
        addr_q <= addr_q + 1'b1;
        iss_q  <= iss_q + 1'b1;
      end
      if (rd_acc) begin
        ret_q     <= ret_q + 1'b1;
        rd_data_q <= mem_rdata;
      end
      rd_vld_q <= rd_acc;
    end
  end

  assign mem_cmd_addr        = addr_q;
  assign rd_burst_data       = rd_data_q;
  assign rd_burst_data_valid = rd_vld_q;

endmodule

// File: tb/tb_sdram_burst_engine.sv
// Self-checking bench for sdram_burst_engine.
// Burst-level model, memory responder and write FIFO model.
module tb_sdram_burst_engine;

  localparam int AW  = 24;
  localparam int DW  = 16;
  localparam int BL  = 256;
  localparam int LAT = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wr_burst_req = 1'b0;
  logic [AW-1:0] wr_burst_addr = '0;
  logic [DW-1:0] wr_burst_data;
  logic          wr_burst_data_req;
  logic          wr_burst_finish;
  logic          rd_burst_req = 1'b0;
  logic [AW-1:0] rd_burst_addr = '0;
  logic [DW-1:0] rd_burst_data;
  logic          rd_burst_data_valid;
  logic          rd_burst_finish;
  logic          mem_cmd_valid;
  logic          mem_cmd_ready = 1'b1;
  logic          mem_cmd_we;
  logic [AW-1:0] mem_cmd_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_rdata_valid = 1'b0;

  sdram_burst_engine dut (
    .clk                 (clk),
    .reset               (reset),
    .wr_burst_req        (wr_burst_req),
    .wr_burst_addr       (wr_burst_addr),
    .wr_burst_data       (wr_burst_data),
    .wr_burst_data_req   (wr_burst_data_req),
    .wr_burst_finish     (wr_burst_finish),
    .rd_burst_req        (rd_burst_req),
    .rd_burst_addr       (rd_burst_addr),
    .rd_burst_data       (rd_burst_data),
    .rd_burst_data_valid (rd_burst_data_valid),
    .rd_burst_finish     (rd_burst_finish),
    .mem_cmd_valid       (mem_cmd_valid),
    .mem_cmd_ready       (mem_cmd_ready),
    .mem_cmd_we          (mem_cmd_we),
    .mem_cmd_addr        (mem_cmd_addr),
    .mem_wdata           (mem_wdata),
    .mem_rdata           (mem_rdata),
    .mem_rdata_valid     (mem_rdata_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            rd;
    logic [AW-1:0] addr;
  } burst_t;

  typedef struct {
    logic [AW-1:0] a;
    int            due;
  } rq_t;

  int n_chk = 0;
  int n_fail = 0;

  burst_t        exp_q[$];
  burst_t        cur;
  bit            in_burst = 0;
  int            cur_iss = 0;
  int            cur_ret = 0;
  int            widx = 0;
  logic [DW-1:0] exp_rd[$];
  rq_t           rq[$];
  bit            fin_order[$];
  int            fin_total = 0;
  int            rd_words = 0;
  logic [AW-1:0] first_addr;
  logic [AW-1:0] last_addr;
  bit            got_first = 0;
  int            cyc = 0;
  int            fptr = 0;
  bit            pop_pend = 0;
  bit            toggle = 0;
  bit            hold_rdy = 0;
  bit            stray = 0;
  bit            hold = 0;
  logic [AW-1:0] h_addr;
  logic          h_we;
  logic [DW-1:0] h_wd;

  function automatic logic [DW-1:0] wf(int i);
    logic [31:0] v;
    v = i * 40503 + 32'h1234;
    return v[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] mdat(logic [AW-1:0] a);
    return a[15:0] ^ {a[23:16], 8'h5A};
  endfunction

  assign wr_burst_data = wf(fptr);

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bad(string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: unexpected event", name);
  endtask

  // Memory side: ready pattern, FIFO pop, in-order read returns.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (pop_pend) begin
      fptr++;
      pop_pend = 0;
    end
    if (hold_rdy) mem_cmd_ready = 1'b0;
    else if (toggle) mem_cmd_ready = 1'($urandom % 2);
    else mem_cmd_ready = 1'b1;
    if (rq.size() > 0 && rq[0].due <= cyc) begin
      mem_rdata_valid = 1'b1;
      mem_rdata = mdat(rq[0].a);
      void'(rq.pop_front());
    end else begin
      mem_rdata_valid = stray;
      mem_rdata = 16'($urandom);
    end
  end

  // Compare process against the burst-level model.
  always @(negedge clk) begin
    logic fire;
    logic [AW-1:0] ea;
    if (reset) begin
      in_burst = 0;
      exp_rd.delete();
      rq.delete();
      hold = 0;
    end else begin
      fire = mem_cmd_valid && mem_cmd_ready;
      chk("data_req", 32'(wr_burst_data_req),
          32'(fire && mem_cmd_we));
      if (wr_burst_data_req) pop_pend = 1;
      if (hold) begin
        chk("hold_valid", 32'(mem_cmd_valid), 32'd1);
        chk("hold_addr", 32'(mem_cmd_addr), 32'(h_addr));
        chk("hold_we", 32'(mem_cmd_we), 32'(h_we));
        chk("hold_wdata", 32'(mem_wdata), 32'(h_wd));
      end
      hold = mem_cmd_valid && !mem_cmd_ready;
      h_addr = mem_cmd_addr;
      h_we = mem_cmd_we;
      h_wd = mem_wdata;
      if (fire) begin
        if (!in_burst) begin
          if (exp_q.size() == 0) begin
            bad("burst_start");
            cur.rd = !mem_cmd_we;
            cur.addr = mem_cmd_addr;
          end else begin
            cur = exp_q.pop_front();
          end
          in_burst = 1;
          cur_iss = 0;
          cur_ret = 0;
          if (!got_first) first_addr = mem_cmd_addr;
          got_first = 1;
        end
        ea = cur.addr + AW'(cur_iss);
        chk("cmd_we", 32'(mem_cmd_we), 32'(!cur.rd));
        chk("cmd_addr", 32'(mem_cmd_addr), 32'(ea));
        if (mem_cmd_we) begin
          chk("wdata", 32'(mem_wdata), 32'(wf(widx)));
          widx++;
        end else begin
          exp_rd.push_back(mdat(mem_cmd_addr));
          rq.push_back('{a: mem_cmd_addr, due: cyc + LAT});
        end
        cur_iss++;
        last_addr = mem_cmd_addr;
      end
      if (rd_burst_data_valid) begin
        if (exp_rd.size() == 0) bad("rd_extra");
        else chk("rd_data", 32'(rd_burst_data),
                 32'(exp_rd.pop_front()));
        cur_ret++;
        rd_words++;
      end
      if (wr_burst_finish || rd_burst_finish) begin
        chk("fin_both", 32'(wr_burst_finish && rd_burst_finish),
            32'd0);
        if (!in_burst) begin
          bad("fin_orphan");
        end else begin
          chk("fin_kind", 32'(rd_burst_finish), 32'(cur.rd));
          chk("fin_cmds", 32'(cur_iss), 32'(BL));
          if (cur.rd) chk("fin_rets", 32'(cur_ret), 32'(BL));
        end
        fin_order.push_back(rd_burst_finish);
        in_burst = 0;
        fin_total++;
      end
    end
  end

  task automatic run(int nfin, int budget, string name);
    int tgt;
    int n;
    tgt = fin_total + nfin;
    n = 0;
    while (fin_total < tgt && n < budget) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (fin_total < tgt) bad({name, "_timeout"});
  endtask

  task automatic reset_outs(string name);
    chk({name, "_valid"}, 32'(mem_cmd_valid), 32'd0);
    chk({name, "_we"}, 32'(mem_cmd_we), 32'd0);
    chk({name, "_addr"}, 32'(mem_cmd_addr), 32'd0);
    chk({name, "_wdata"}, 32'(mem_wdata), 32'd0);
    chk({name, "_rdata"}, 32'(rd_burst_data), 32'd0);
    chk({name, "_rvld"}, 32'(rd_burst_data_valid), 32'd0);
    chk({name, "_pop"}, 32'(wr_burst_data_req), 32'd0);
    chk({name, "_fin"},
        32'({wr_burst_finish, rd_burst_finish}), 32'd0);
  endtask

  initial begin
    int p0;
    int f0;
    int n;
    logic [3:0] fo;
    repeat (3) @(posedge clk);
    #2;
    reset_outs("rst");
    reset = 1'b0;

    // Single read burst at 0x000100.
    got_first = 0;
    exp_q.push_back('{rd: 1, addr: 24'h000100});
    rd_burst_addr = 24'h000100;
    rd_burst_req = 1'b1;
    run(1, 3000, "rd1");
    rd_burst_req = 1'b0;
    chk("rd1_first", 32'(first_addr), 32'h000100);
    chk("rd1_last", 32'(last_addr), 32'h0001FF);
    chk("rd1_words", 32'(rd_words), 32'd256);

    // Stray return while idle is dropped.
    repeat (4) @(posedge clk);
    #2;
    stray = 1;
    @(posedge clk);
    #2;
    stray = 0;
    repeat (4) @(posedge clk);
    #2;
    chk("stray_drop", 32'(rd_words), 32'd256);

    // Write burst, ready toggling.
    toggle = 1;
    p0 = fptr;
    got_first = 0;
    exp_q.push_back('{rd: 0, addr: 24'h001F00});
    wr_burst_addr = 24'h001F00;
    wr_burst_req = 1'b1;
    run(1, 4000, "wr1");
    wr_burst_req = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("wr1_pops", 32'(fptr - p0), 32'd256);
    chk("wr1_first", 32'(first_addr), 32'h001F00);
    chk("wr1_last", 32'(last_addr), 32'h001FFF);
    toggle = 0;

    // Both requests held: alternate starting with read.
    fin_order.delete();
    exp_q.push_back('{rd: 1, addr: 24'h004000});
    exp_q.push_back('{rd: 0, addr: 24'h005000});
    exp_q.push_back('{rd: 1, addr: 24'h004000});
    exp_q.push_back('{rd: 0, addr: 24'h005000});
    rd_burst_addr = 24'h004000;
    wr_burst_addr = 24'h005000;
    rd_burst_req = 1'b1;
    wr_burst_req = 1'b1;
    run(4, 12000, "both");
    rd_burst_req = 1'b0;
    wr_burst_req = 1'b0;
    chk("both_n", 32'(fin_order.size()), 32'd4);
    fo = '0;
    if (fin_order.size() == 4)
      fo = {fin_order[0], fin_order[1], fin_order[2], fin_order[3]};
    chk("both_order", 32'(fo), 32'b1010);

    // Read wrapping past all-ones.
    repeat (3) @(posedge clk);
    #2;
    got_first = 0;
    exp_q.push_back('{rd: 1, addr: 24'hFFFFF0});
    rd_burst_addr = 24'hFFFFF0;
    rd_burst_req = 1'b1;
    run(1, 3000, "wrap");
    rd_burst_req = 1'b0;
    chk("wrap_first", 32'(first_addr), 32'hFFFFF0);
    chk("wrap_last", 32'(last_addr), 32'h0000EF);

    // Reset at word 100 of a write.
    repeat (3) @(posedge clk);
    #2;
    exp_q.push_back('{rd: 0, addr: 24'h002000});
    wr_burst_addr = 24'h002000;
    wr_burst_req = 1'b1;
    n = 0;
    while (!(in_burst && cur_iss == 100) && n < 2000) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (n >= 2000) bad("abort_wait");
    f0 = fin_total;
    reset = 1'b1;
    hold_rdy = 1;
    mem_cmd_ready = 1'b0;
    wr_burst_req = 1'b0;
    @(posedge clk);
    #2;
    reset_outs("abort");
    @(posedge clk);
    #2;
    reset = 1'b0;
    hold_rdy = 0;
    repeat (10) @(posedge clk);
    #2;
    chk("abort_nofin", 32'(fin_total), 32'(f0));
    got_first = 0;
    exp_q.push_back('{rd: 0, addr: 24'h003000});
    wr_burst_addr = 24'h003000;
    wr_burst_req = 1'b1;
    run(1, 3000, "post");
    wr_burst_req = 1'b0;
    chk("post_first", 32'(first_addr), 32'h003000);
    chk("post_last", 32'(last_addr), 32'h0030FF);

    // Held read, address bumped on each finish.
    repeat (3) @(posedge clk);
    #2;
    rd_burst_addr = 24'h007000;
    exp_q.push_back('{rd: 1, addr: 24'h007000});
    rd_burst_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      run(1, 3000, "b2b");
      if (k < 2) begin
        rd_burst_addr = rd_burst_addr + 24'h000100;
        exp_q.push_back('{rd: 1, addr: rd_burst_addr});
      end
    end
    rd_burst_req = 1'b0;
    chk("b2b_last", 32'(last_addr), 32'h0072FF);
    repeat (10) @(posedge clk);
    #2;
    chk("exp_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
